// File: rtl/chunk_add_seq.sv
// chunk_add_seq: sequential W = N*CHUNKS bit adder.
// It adds one N-bit chunk per cycle through a single carry-lookahead adder and keeps the
// carry in a register between chunks.
// The optional macro CHUNK_ADD_SEQ_OVF_EN adds a registered signed-overflow output, ovf_o.

// N-bit carry-lookahead adder.
// Group generate/propagate signals come from a log-depth prefix network.
module chunk_add_seq_cla #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] prop;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    logic [N:0]   carry;

    // Prefix network: after it runs, gg[i]/pp[i] cover bits i..0.
    always_comb begin
        prop = a_i ^ b_i;
        gg   = a_i & b_i;
        pp   = prop;
        gn   = '0;
        pn   = '0;
        for (int s = 0; (1 << s) < N; s++) begin
            gn = gg;
            pn = pp;
            for (int i = (1 << s); i < N; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i - (1 << s)]);
                pn[i] = pp[i] & pp[i - (1 << s)];
            end
            gg = gn;
            pp = pn;
        end
        carry[0] = cin_i;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gg[i] | (pp[i] & cin_i);
        end
        sum_o  = prop ^ carry[N-1:0];
        cout_o = carry[N];
    end

endmodule

module chunk_add_seq #(
    parameter int unsigned N      = 32,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [N*CHUNKS-1:0] a_i,
    input  logic [N*CHUNKS-1:0] b_i,
    input  logic                cin_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N*CHUNKS-1:0] y_o,
    output logic                cout_o
`ifdef CHUNK_ADD_SEQ_OVF_EN
    ,
    output logic                ovf_o
`endif
);

    localparam int unsigned W    = N * CHUNKS;
    localparam int unsigned IdxW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      y_q, y_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [N-1:0]      chunk_a;
    logic [N-1:0]      chunk_b;
    logic [N-1:0]      chunk_sum;
    logic              chunk_cout;
    logic              last_chunk;

`ifdef CHUNK_ADD_SEQ_OVF_EN
    logic              ovf_q, ovf_d;
    logic              chunk_ovf;
`endif

    assign chunk_a    = a_q[N*int'(idx_q) +: N];
    assign chunk_b    = b_q[N*int'(idx_q) +: N];
    assign last_chunk = (idx_q == IdxW'(CHUNKS - 1));

    chunk_add_seq_cla #(
        .N (N)
    ) u_cla (
        .a_i    (chunk_a),
        .b_i    (chunk_b),
        .cin_i  (carry_q),
        .sum_o  (chunk_sum),
        .cout_o (chunk_cout)
    );

`ifdef CHUNK_ADD_SEQ_OVF_EN
    // Equal operand signs with a differing sum sign is equivalent to carry-in(msb) ^ carry-out.
    assign chunk_ovf = (chunk_a[N-1] ~^ chunk_b[N-1]) & (chunk_sum[N-1] ^ chunk_a[N-1]);
`endif

    // Next-state logic for the FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CHUNK_ADD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                y_d[N*int'(idx_q) +: N] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = idx_q + IdxW'(1);
                if (last_chunk) begin
                    cout_d  = chunk_cout;
`ifdef CHUNK_ADD_SEQ_OVF_EN
                    ovf_d   = chunk_ovf;
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CHUNK_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CHUNK_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign y_o         = y_q;
    assign cout_o      = cout_q;
`ifdef CHUNK_ADD_SEQ_OVF_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_chunk_add_seq.sv
// Directed bench for chunk_add_seq with N=8 and CHUNKS=4.
module tb_chunk_add_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        cout;
`ifdef CHUNK_ADD_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    chunk_add_seq #(
        .N      (8),
        .CHUNKS (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .cout_o      (cout)
`ifdef CHUNK_ADD_SEQ_OVF_EN
        ,
        .ovf_o       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one request at a negedge and returns at the negedge after the accepting edge.
    task automatic accept(input logic [31:0] av, input logic [31:0] bv, input logic cv);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges until out_valid is seen; 20 means the wait timed out.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b y=%h cout=%b want 1 0 0 0",
                     in_ready, out_valid, y, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        accept(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles want 4", cyc);
        end
        checks++;
        if (y !== 32'h0000_0100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: y=%h cout=%b want 00000100 0", y, cout);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_done: got %b want 0", in_ready);
        end
        pop();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        accept(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_valid(cyc);
        checks++;
        if (cyc !== 4 || y !== 32'h0000_0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL wrap: cyc=%0d y=%h cout=%b want 4 00000000 1", cyc, y, cout);
        end
`ifdef CHUNK_ADD_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf: got %b want 0", ovf);
        end
`endif
        pop();
    endtask

    task automatic test_overflow();
        int cyc;
        accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(cyc);
        checks++;
        if (y !== 32'h8000_0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sum: y=%h cout=%b want 80000000 0", y, cout);
        end
`ifdef CHUNK_ADD_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_ovf: got %b want 1", ovf);
        end
`endif
        pop();
        // Per-chunk carries in both directions: 0x12345678 + 0x0FEDCBA8 + 1 = 0x22222221.
        accept(32'h1234_5678, 32'h0FED_CBA8, 1'b1);
        wait_valid(cyc);
        checks++;
        if (y !== 32'h2222_2221 || cout !== 1'b0) begin
            errors++;
            $display("FAIL mixed_sum: y=%h cout=%b want 22222221 0", y, cout);
        end
        pop();
        // 0x80000000 + 0x80000000 -> y=0, cout=1, signed overflow.
        accept(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_valid(cyc);
        checks++;
        if (y !== 32'h0000_0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL neg_sum: y=%h cout=%b want 00000000 1", y, cout);
        end
`ifdef CHUNK_ADD_SEQ_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL neg_ovf: got %b want 1", ovf);
        end
`endif
        pop();
    endtask

    task automatic test_stall();
        int cyc;
        int extra;
        accept(32'h0001_0203, 32'h1010_1010, 1'b0);
        // Stray request during BUSY and DONE must be ignored.
        a = 32'hDEAD_BEEF;
        b = 32'h1111_1111;
        in_valid = 1'b1;
        wait_valid(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL stall_latency: got %0d want 4", cyc);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (y !== 32'h1011_1213 || cout !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1)
            begin
                errors++;
                $display("FAIL stall_hold: y=%h cout=%b in_ready=%b out_valid=%b want 10111213 0 0 1",
                         y, cout, in_ready, out_valid);
            end
        end
        pop();
        in_valid = 1'b0;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL stall_no_extra: out_valid cycles %0d want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int seen;
        accept(32'h5555_5555, 32'h3333_3333, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b y=%h cout=%b want 1 0 0 0",
                     in_ready, out_valid, y, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid cycles %0d want 0", seen);
        end
        accept(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        wait_valid(cyc);
        checks++;
        if (cyc !== 4 || y !== 32'h0001_0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_next: cyc=%0d y=%h cout=%b want 4 00010000 0", cyc, y, cout);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad = 0;
        logic [32:0] s;
        logic [31:0] av;
        logic [31:0] bv;
        logic        cv;
        for (int k = 0; k < 1000; k++) begin
            av = $urandom;
            bv = $urandom;
            cv = 1'($urandom_range(0, 1));
            s = {1'b0, av} + {1'b0, bv} + {32'h0, cv};
            accept(av, bv, cv);
            wait_valid(cyc);
            for (int st = $urandom_range(0, 3); st > 0; st--) @(negedge clk);
            checks++;
            if (cyc >= 20 || y !== s[31:0] || cout !== s[32]) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d: y=%h cout=%b want %h %b", k, y, cout, s[31:0], s[32]);
            end
            pop();
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_add_seq.md
CHUNK_ADD_SEQ -- requirements
Module: chunk_add_seq

Interface
REQ-001 Parameter N, default 32: chunk width in bits; each chunk is summed by one internal cla instance of width N.
REQ-002 Parameter CHUNKS, default 4: number of chunks; operand width W = N*CHUNKS; CHUNKS >= 1.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  W  first operand.
REQ-008 b  input  W  second operand.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 y  output  W  sum, registered.
REQ-013 cout  output  1  carry out of bit W-1, registered.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-015 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-016 IDLE with in_valid=1: latch a, b, cin into operand registers, clear chunk index to 0, go to BUSY.
REQ-017 IDLE with in_valid=0: stay in IDLE; registers unchanged.
REQ-018 BUSY, each cycle: chunk idx of operand registers (bits idx*N+N-1..idx*N) plus the carry register go through the cla instance; sum written to y bits idx*N+N-1..idx*N; carry register <= chunk carry-out; idx <= idx+1.
REQ-019 Carry register SHALL load cin on acceptance and carry only between chunks of the same request.
REQ-020 After the BUSY cycle with idx = CHUNKS-1: cout <= final carry, go to DONE.
REQ-021 Latency: request accepted at edge T -> out_valid high after edge T+CHUNKS.
REQ-022 DONE: y, cout held stable while out_ready=0; out_ready=1 -> go to IDLE on that edge.
REQ-023 in_valid, a, b, cin SHALL be ignored outside IDLE; no request is queued.
REQ-024 Peak throughput: one request per CHUNKS+2 cycles (IDLE, CHUNKS x BUSY, DONE).
REQ-025 y and cout SHALL equal (a + b + cin) mod 2^W and bit W of that sum respectively; full wrap-around SHALL give y=0, cout=1.
REQ-026 y bits of chunks not yet computed SHALL hold previous values during BUSY; only DONE contents are defined.
REQ-027 CHUNKS=1: single BUSY cycle, then DONE.
REQ-028 Chunk index width SHALL be max(1, ceil(log2(CHUNKS))) bits.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, y=0, cout=0, carry register=0, idx=0, operand registers=0.
REQ-030 Reset during BUSY or DONE SHALL abort the request; no out_valid is produced for it.
REQ-031 First request acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro CHUNK_ADD_SEQ_OVF_EN: when defined, adds output ovf (1 bit, registered): signed two's-complement overflow of a + b + cin, i.e. carry into bit W-1 XOR carry out of bit W-1, updated with cout, reset 0, held in DONE.
REQ-033 Without CHUNK_ADD_SEQ_OVF_EN the ovf port and its logic SHALL not exist; all other behaviour identical.

Verification (N=8, CHUNKS=4, W=32)
REQ-034 a=0x0000_00FF, b=0x0000_0001, cin=0 -> y=0x0000_0100, cout=0, out_valid 4 cycles after acceptance.
REQ-035 a=0xFFFF_FFFF, b=0, cin=1 -> y=0x0000_0000, cout=1 (carry ripples through all 4 chunks); with OVF_EN, ovf=0.
REQ-036 a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> y=0x8000_0000, cout=0; with OVF_EN, ovf=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> y, cout stable, in_ready=0; new in_valid pulse during BUSY/DONE -> ignored, no extra result.
REQ-038 rst_n pulsed low during second BUSY cycle -> immediately IDLE, y=0, cout=0, out_valid never asserted; next request completes correctly.
REQ-039 1000 random back-to-back requests with random out_ready stalls -> every result matches (a+b+cin) mod 2^32 and carry bit.
